// File: rtl/kbd_operand_loader.sv
// kbd_operand_loader: synchronizes DIP switches and debounces ENTER/CLEAR,
// then commits the nibble as operand A, then operand B, for the 4-bit keyboard adder.
// Latency: a press is seen DEBOUNCE_CYCLES+1 edges after the first high sample; no backpressure.
// Ports: clk, rst_n (sync, active-low); key_code[3:0], key_enter, key_clear (raw, async);
//        kbd1[4:1], kbd2[4:1] (operands, [1] = LSB), operands_valid, phase[1:0] (00 A, 01 B, 10 SHOW).
module kbd_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_enter,
  input  logic       key_clear,
  output logic [4:1] kbd1,
  output logic [4:1] kbd2,
  output logic       operands_valid,
  output logic [1:0] phase
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_ENTER_A = 2'b00;
  localparam logic [1:0] ST_ENTER_B = 2'b01;
  localparam logic [1:0] ST_SHOW    = 2'b10;

  // Button index 0 = ENTER, 1 = CLEAR.
  localparam int BTN_ENTER = 0;
  localparam int BTN_CLEAR = 1;

  // Two-flop synchronizers, deliberately left out of reset.
  logic [3:0] code_m, code_s;
  logic [1:0] btn_m, btn_s;

  always_ff @(posedge clk) begin
    code_m <= key_code;
    code_s <= code_m;
    btn_m  <= {key_clear, key_enter};
    btn_s  <= btn_m;
  end

  // Debouncers. 'armed' blocks events until the button has been seen
  // released (debounced) since reset, so a button held through reset
  // cannot fire on its own.
  logic [1:0]    btn_db;
  logic [1:0]    armed;
  logic [CW-1:0] cnt [2];
  logic [1:0]    press_evt;

  always_comb begin
    press_evt = 2'b00;
    for (int i = 0; i < 2; i++) begin
      press_evt[i] = btn_s[i] && !btn_db[i] && (cnt[i] == CNT_MAX) && armed[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_db <= 2'b00;
      armed  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s[i] == btn_db[i]) begin
          if (!armed[i] && !btn_db[i]) begin
            // Not yet armed: require a full debounce window of "released".
            if (cnt[i] == CNT_MAX) begin
              armed[i] <= 1'b1;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end else begin
            cnt[i] <= '0;
          end
        end else if (cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else begin
          btn_db[i] <= btn_s[i];
          cnt[i]    <= '0;
          if (!btn_s[i]) begin
            armed[i] <= 1'b1;
          end
        end
      end
    end
  end

  wire enter_evt = press_evt[BTN_ENTER];
  wire clear_evt = press_evt[BTN_CLEAR];

  // Operand FSM; CLEAR wins over ENTER on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kbd1           <= 4'b0000;
      kbd2           <= 4'b0000;
      operands_valid <= 1'b0;
      phase          <= ST_ENTER_A;
    end else if (clear_evt) begin
      kbd1           <= 4'b0000;
      kbd2           <= 4'b0000;
      operands_valid <= 1'b0;
      phase          <= ST_ENTER_A;
    end else if (enter_evt) begin
      case (phase)
        ST_ENTER_A: begin
          kbd1  <= code_s;
          phase <= ST_ENTER_B;
        end
        ST_ENTER_B: begin
          kbd2           <= code_s;
          operands_valid <= 1'b1;
          phase          <= ST_SHOW;
        end
        ST_SHOW: begin
          // New pair starts; previous B stays visible until overwritten.
          kbd1           <= code_s;
          operands_valid <= 1'b0;
          phase          <= ST_ENTER_B;
        end
        default: begin
          kbd1           <= 4'b0000;
          kbd2           <= 4'b0000;
          operands_valid <= 1'b0;
          phase          <= ST_ENTER_A;
        end
      endcase
    end
  end

endmodule
